uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UartTx transmitter among NUM_REQ byte-stream requesters using round-robin arbitration.
- Sequences the transmitter's write/busy handshake: one-cycle write pulse, wait for busy to rise, wait for busy to fall.
- Sits between client logic (command responder, log streamer, etc.) and the transmit half of Uart.
- Detects a transmitter that never asserts busy and reports it instead of hanging.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- BUSY_TIMEOUT, 16, clock cycles allowed after the write pulse for tx_busy_i to rise (1..255).

Ports:
- clock_i  input  1  system clock; all state updates on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester "byte pending"; held high until the matching ack_o.
- data_i  input  8*NUM_REQ  requester bytes; requester n occupies bits [8n+7:8n]; stable while req_i[n] is high.
- lock_i  input  NUM_REQ  per-requester packet lock; used only with UART_ARB_LOCK_EN.
- ack_o  output  NUM_REQ  one-cycle pulse: byte of requester n captured.
- tx_write_o  output  1  to UartTx write_i; one-cycle pulse.
- tx_data_o  output  8  to UartTx data_i; registered, held until the next grant.
- tx_busy_i  input  1  from UartTx busy_o.
- grant_o  output  3  index of the last granted requester.
- active_o  output  1  high in every state except IDLE.
- timeout_o  output  1  one-cycle pulse when the busy wait expires.

Behaviour:
- Reset values (asynchronous, on reset_i high): state IDLE, ack_o=0, tx_write_o=0, tx_data_o=0, grant_o=NUM_REQ-1, active_o=0, timeout_o=0, timeout counter 0.
- Reset mid-transfer aborts immediately. No write is reissued after reset deasserts.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_i bit is set and tx_busy_i=0, pick the winner and go to ISSUE.
  - Winner = first set req_i bit scanning upward from grant_o+1, wrapping modulo NUM_REQ.
  - On that edge: grant_o and tx_data_o are loaded from the winner.
  - If tx_busy_i=1, stay in IDLE; no grant is made.
- ISSUE (exactly 1 cycle):
  - tx_write_o=1 and ack_o[grant_o]=1 in this cycle; all other ack_o bits are 0.
  - Next state WAIT_BUSY; timeout counter cleared.
- WAIT_BUSY:
  - tx_busy_i=1 -> go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT, pulse timeout_o for 1 cycle and go to IDLE.
  - Total cycles spent in WAIT_BUSY before the timeout exit = BUSY_TIMEOUT.
- WAIT_DONE: tx_busy_i=0 -> IDLE; otherwise stay.
- Latency: req_i sampled high in IDLE at edge k -> tx_write_o and ack_o high for the cycle after edge k.
- Fairness: a requester that keeps req_i high after its ack is not granted again while any other requester is pending.
- Requester rules:
  - The requester may drop req_i or present a new byte in the cycle after ack_o.
  - A req_i that drops before its grant is simply not served.
  - req_i bits changing while not in IDLE have no effect until IDLE.
- Simultaneous events:
  - All requests high from reset: grant order is 0,1,2,3,0,...
  - tx_busy_i already high when entering WAIT_BUSY: move to WAIT_DONE on the next edge.
- tx_busy_i rising during IDLE (external write): the arbiter holds off and keeps no state.
- Width rules:
  - The timeout counter is 8 bits and saturates; it never wraps.
  - grant_o upper bits are 0 when NUM_REQ<8.

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- Defined:
  - On return to IDLE, if lock_i[grant_o]=1 and req_i[grant_o]=1, the same requester is granted again ahead of round-robin order. This keeps multi-byte packets contiguous.
  - On a timeout exit, the lock is ignored for that arbitration.
- Not defined: lock_i is ignored (port kept, unused) and pure round-robin applies.

Test Plan:
- Reset then req_i=4'b0001, data_i[7:0]=8'h55, UartTx model raises busy 1 cycle after the write and holds it for 10 cycles -> exactly one tx_write_o pulse with tx_data_o=8'h55; ack_o=4'b0001 in the same cycle; active_o returns to 0 the cycle after busy falls.
- req_i=4'b1111 held, bytes 8'hA0..8'hA3 -> tx_data_o sequence A0,A1,A2,A3,A0; grant_o 0,1,2,3,0.
- grant_o=1 with req_i=4'b1001 pending -> next grant is 3, then 0.
- Busy model stuck at 0, BUSY_TIMEOUT=16 -> timeout_o pulses 16 cycles after WAIT_BUSY entry; FSM in IDLE; the next request is served normally.
- Assert reset_i during WAIT_DONE -> all outputs at reset values asynchronously; after release with tx_busy_i=0 and req_i=0, no tx_write_o pulse.
- UART_ARB_LOCK_EN defined, requester 2 with lock_i[2]=1 for 3 bytes while req 0 is pending -> three consecutive grants to 2, then grant to 0; without the macro, grants alternate 2,0,2.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte requesters.
// Round-robin arbitration, one-cycle write pulse to the transmitter, then waits
// for busy to rise and fall. A transmitter that never raises busy is reported on
// timeout_o instead of stalling the arbiter.
//
// Optional feature macro: UART_ARB_LOCK_EN
//   defined   : a locked requester with a pending byte is re-granted on return
//               to IDLE, keeping multi-byte packets contiguous (not after timeout).
//   undefined : lock_i is ignored; pure round-robin.
//
// Ports:
//   clock_i     system clock, rising edge
//   reset_i     asynchronous active-high reset
//   req_i       per-requester byte pending, held until ack_o
//   data_i      requester bytes, requester n at [8n+7:8n]
//   lock_i      per-requester packet lock (UART_ARB_LOCK_EN only)
//   ack_o       one-cycle pulse: byte of requester n captured
//   tx_write_o  one-cycle write pulse to the transmitter
//   tx_data_o   byte to the transmitter, held until the next grant
//   tx_busy_i   transmitter busy
//   grant_o     index of the last granted requester
//   active_o    high whenever the FSM is not IDLE
//   timeout_o   one-cycle pulse when busy never rose after a write
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [8*NUM_REQ-1:0]   data_i,
  input  logic [NUM_REQ-1:0]     lock_i,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic                   tx_write_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_busy_i,
  output logic [2:0]             grant_o,
  output logic                   active_o,
  output logic                   timeout_o
);

  localparam int unsigned IW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]  TIMEOUT_LIM = 8'(BUSY_TIMEOUT);
  localparam logic [2:0]  GRANT_RST   = 3'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic        lock_arm;   // set on a normal return to IDLE, cleared by timeout
  logic [2:0]  rr_winner;
  logic [2:0]  winner;
  logic [7:0]  win_data;
  int unsigned idx;
  logic        found;

  // Round-robin scan upward from the last grant, wrapping modulo NUM_REQ.
  always_comb begin
    rr_winner = grant_o;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(grant_o) + i) % NUM_REQ;
      if (!found && req_i[IW'(idx)]) begin
        rr_winner = 3'(idx);
        found     = 1'b1;
      end
    end
  end

  // Lock override ahead of round-robin order.
`ifdef UART_ARB_LOCK_EN
  always_comb begin
    winner = rr_winner;
    if (lock_arm && lock_i[grant_o[IW-1:0]] && req_i[grant_o[IW-1:0]]) begin
      winner = grant_o;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^{lock_i, lock_arm};
  always_comb begin
    winner = rr_winner;
  end
`endif

  // Byte of the selected requester.
  always_comb begin
    win_data = 8'h00;
    for (int unsigned n = 0; n < NUM_REQ; n++) begin
      if (32'(winner) == n) begin
        win_data = data_i[8*n +: 8];
      end
    end
  end

  // Saturating increment so the busy-wait counter never wraps.
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  // Arbitration and handshake FSM with registered outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      ack_o      <= '0;
      tx_write_o <= 1'b0;
      tx_data_o  <= 8'h00;
      grant_o    <= GRANT_RST;
      active_o   <= 1'b0;
      timeout_o  <= 1'b0;
      cnt        <= 8'h00;
      lock_arm   <= 1'b0;
    end else begin
      tx_write_o <= 1'b0;
      ack_o      <= '0;
      timeout_o  <= 1'b0;
      case (state)
        IDLE: begin
          // External traffic on the transmitter holds off any grant.
          if ((|req_i) && !tx_busy_i) begin
            state      <= ISSUE;
            grant_o    <= winner;
            tx_data_o  <= win_data;
            tx_write_o <= 1'b1;
            ack_o      <= NUM_REQ'(1'b1) << winner;
            active_o   <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
          cnt   <= 8'h00;
        end
        WAIT_BUSY: begin
          if (tx_busy_i) begin
            state <= WAIT_DONE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == TIMEOUT_LIM) begin
              timeout_o <= 1'b1;
              state     <= IDLE;
              active_o  <= 1'b0;
              lock_arm  <= 1'b0;
            end
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            state    <= IDLE;
            active_o <= 1'b0;
            lock_arm <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          active_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, BUSY_TIMEOUT=16) with a
// simple transmitter model: busy rises one cycle after a write, holds 10 cycles.
module tb_uart_tx_arbiter;

  logic        clock_i;
  logic        reset_i;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  lock_i;
  logic [3:0]  ack_o;
  logic        tx_write_o;
  logic [7:0]  tx_data_o;
  logic        tx_busy_i;
  logic [2:0]  grant_o;
  logic        active_o;
  logic        timeout_o;

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(16)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .req_i(req_i), .data_i(data_i),
    .lock_i(lock_i), .ack_o(ack_o), .tx_write_o(tx_write_o),
    .tx_data_o(tx_data_o), .tx_busy_i(tx_busy_i), .grant_o(grant_o),
    .active_o(active_o), .timeout_o(timeout_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  // Transmitter model.
  logic       stuck;
  logic [3:0] bcnt;
  always @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tx_busy_i <= 1'b0;
      bcnt      <= 4'd0;
    end else if (stuck) begin
      tx_busy_i <= 1'b0;
    end else if (tx_write_o) begin
      tx_busy_i <= 1'b1;
      bcnt      <= 4'd10;
    end else if (bcnt > 4'd1) begin
      bcnt <= bcnt - 4'd1;
    end else begin
      tx_busy_i <= 1'b0;
      bcnt      <= 4'd0;
    end
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned wr_total = 0;
  int unsigned wr_cyc  = 0;
  int unsigned to_cyc  = 0;
  int unsigned to_cnt  = 0;
  logic [2:0]  q_grant[$];
  logic [7:0]  q_data[$];
  logic [3:0]  q_ack[$];
  logic [3:0]  drop_mask;
  logic        lock_test;
  int unsigned n2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: sample at the falling edge, log writes, play the requesters.
  task automatic step();
    @(negedge clock_i);
    cyc++;
    if (timeout_o) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (tx_write_o) begin
      wr_total++;
      wr_cyc = cyc;
      q_grant.push_back(grant_o);
      q_data.push_back(tx_data_o);
      q_ack.push_back(ack_o);
    end
    for (int i = 0; i < 4; i++) begin
      if (ack_o[i] && drop_mask[i]) req_i[i] = 1'b0;
    end
    if (lock_test && ack_o[2]) begin
      n2++;
      if (n2 == 3) begin
        req_i[2]  = 1'b0;
        lock_i[2] = 1'b0;
      end else begin
        data_i[23:16] = data_i[23:16] + 8'd1;
      end
    end
  endtask

  task automatic wait_writes(input string tag, input int unsigned n);
    for (int k = 0; k < 300; k++) begin
      if (q_grant.size() >= n) break;
      step();
    end
    check_eq(tag, q_grant.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 100; k++) begin
      if (!active_o && !tx_busy_i) break;
      step();
    end
    check_eq(tag, {31'd0, active_o}, 32'd0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    stuck   = 1'b0;
    req_i   = 4'b0000;
    lock_i  = 4'b0000;
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  task automatic clear_q();
    q_grant.delete();
    q_data.delete();
    q_ack.delete();
  endtask

  logic prev_busy;
  int unsigned base;

  initial begin
    reset_i = 1'b1; stuck = 1'b0; req_i = '0; lock_i = '0; data_i = '0;
    drop_mask = 4'b1111; lock_test = 1'b0; n2 = 0;
    @(negedge clock_i);
    check_eq("rst_ack", ack_o, 0);
    check_eq("rst_write", tx_write_o, 0);
    check_eq("rst_data", tx_data_o, 0);
    check_eq("rst_grant", grant_o, 3);
    check_eq("rst_active", active_o, 0);
    check_eq("rst_timeout", timeout_o, 0);
    @(negedge clock_i);
    reset_i = 1'b0;

    // Single byte from requester 0.
    data_i[7:0] = 8'h55;
    req_i = 4'b0001;
    wait_writes("t1_write", 1);
    check_eq("t1_data", q_data[0], 8'h55);
    check_eq("t1_ack", q_ack[0], 4'b0001);
    prev_busy = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (prev_busy && !tx_busy_i) begin
        check_eq("t1_act_hold", active_o, 1);
        step();
        check_eq("t1_act_fall", active_o, 0);
        break;
      end
      prev_busy = tx_busy_i;
    end
    repeat (10) step();
    check_eq("t1_one_write", wr_total, 1);

    // All requesters held: order 0,1,2,3,0.
    do_reset();
    clear_q();
    drop_mask = 4'b0000;
    data_i = 32'hA3A2A1A0;
    req_i = 4'b1111;
    wait_writes("t2_writes", 5);
    req_i = 4'b0000;
    wait_idle("t2_idle");
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t2_grant%0d", i), q_grant[i], i % 4);
      check_eq($sformatf("t2_data%0d", i), q_data[i], 8'hA0 + 8'(i % 4));
    end

    // From grant 1 with requesters 0 and 3 pending: 3 then 0.
    do_reset();
    clear_q();
    drop_mask = 4'b1111;
    req_i = 4'b0010;
    wait_writes("t3_prep", 1);
    wait_idle("t3_prep_idle");
    check_eq("t3_grant1", grant_o, 1);
    clear_q();
    drop_mask = 4'b0000;
    req_i = 4'b1001;
    wait_writes("t3_writes", 2);
    req_i = 4'b0000;
    wait_idle("t3_idle");
    check_eq("t3_first", q_grant[0], 3);
    check_eq("t3_second", q_grant[1], 0);

    // Transmitter never raises busy.
    clear_q();
    drop_mask = 4'b1111;
    stuck = 1'b1;
    to_cnt = 0;
    req_i = 4'b0001;
    wait_writes("t4_write", 1);
    base = wr_cyc;
    for (int k = 0; k < 40; k++) begin
      step();
      if (to_cnt != 0) break;
    end
    check_eq("t4_to_seen", to_cnt, 1);
    check_eq("t4_to_delay", to_cyc - base, 17);
    check_eq("t4_to_idle", active_o, 0);
    step();
    check_eq("t4_to_pulse", timeout_o, 0);
    stuck = 1'b0;
    clear_q();
    data_i[23:16] = 8'h5A;
    req_i = 4'b0100;
    wait_writes("t4_next", 1);
    check_eq("t4_next_grant", q_grant[0], 2);
    check_eq("t4_next_data", q_data[0], 8'h5A);
    wait_idle("t4_idle");

    // Reset during WAIT_DONE aborts and reissues nothing.
    clear_q();
    data_i[7:0] = 8'h77;
    req_i = 4'b0001;
    wait_writes("t5_write", 1);
    repeat (4) step();
    check_eq("t5_pre_active", active_o, 1);
    check_eq("t5_pre_busy", tx_busy_i, 1);
    #2 reset_i = 1'b1;
    #1;
    check_eq("t5_ack", ack_o, 0);
    check_eq("t5_data", tx_data_o, 0);
    check_eq("t5_grant", grant_o, 3);
    check_eq("t5_active", active_o, 0);
    check_eq("t5_timeout", timeout_o, 0);
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;
    base = wr_total;
    repeat (20) step();
    check_eq("t5_no_write", wr_total - base, 0);

    // Requester 2 sends a locked 3-byte packet while requester 0 waits.
    do_reset();
    clear_q();
    drop_mask = 4'b1111;
    req_i = 4'b0010;
    wait_writes("t6_prep", 1);
    wait_idle("t6_prep_idle");
    clear_q();
    drop_mask = 4'b0001;
    lock_test = 1'b1;
    n2 = 0;
    data_i[23:16] = 8'hC0;
    lock_i = 4'b0100;
    req_i = 4'b0101;
    wait_writes("t6_writes", 4);
    wait_idle("t6_idle");
    lock_test = 1'b0;
`ifdef UART_ARB_LOCK_EN
    check_eq("t6_g0", q_grant[0], 2);
    check_eq("t6_g1", q_grant[1], 2);
    check_eq("t6_g2", q_grant[2], 2);
    check_eq("t6_g3", q_grant[3], 0);
`else
    check_eq("t6_g0", q_grant[0], 2);
    check_eq("t6_g1", q_grant[1], 0);
    check_eq("t6_g2", q_grant[2], 2);
    check_eq("t6_g3", q_grant[3], 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
